exe_mem_pipe_reg: RTL and testbench

Elastic EXE→MEM pipeline register for the MIPS pipeline, the parametrised successor of the fixed-width, always-enabled EX/MEM latch. It carries the EXE-stage payload: PC, ALU result, store value, destination register and MEM/WB control bits. It adds a valid/ready handshake with a two-entry skid buffer, so a stalled MEM stage (e.g. multi-cycle data memory) back-pressures EXE without a combinational ready path. It also provides a synchronous flush for branch/exception squash.

---
 rtl/exe_mem_pkg.sv | 28 ++
 rtl/payload_slot.sv | 35 +++
 rtl/exe_mem_pipe_reg.sv | 153 +++++++++++++++
 tb/tb_exe_mem_pipe_reg.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/exe_mem_pkg.sv
// Shared definitions for the EXE->MEM elastic pipeline register.
// Holds the default payload widths, the packed payload record and the
// occupancy state encoding used by the top-level controller.
package exe_mem_pkg;

   localparam int PC_W   = 32;
   localparam int DATA_W = 32;
   localparam int DEST_W = 5;

   // One EXE-stage instruction as it travels into MEM, at default widths.
   typedef struct packed {
      logic [PC_W-1:0]   pc;
      logic [DATA_W-1:0] alu_result;
      logic [DATA_W-1:0] st_value;
      logic [DEST_W-1:0] dest;
      logic              mem_r_en;
      logic              mem_w_en;
      logic              wb_en;
   } exe_mem_payload_t;

   // Encoding doubles as the entry count driven on the occupancy port.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_e;

endpackage

// File: rtl/payload_slot.sv
// Payload storage slot: a W-bit register with load enable and an
// asynchronous active-low clear.
// Ports:
//   clk_i   - clock
//   rst_ni  - asynchronous active-low clear
//   load_i  - capture d_i on the rising edge
//   d_i     - next payload
//   q_o     - stored payload
module payload_slot #(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         load_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] slot_q;

   // Payload register: cleared on reset, otherwise loads on demand and
   // keeps its (possibly stale) content when not loaded.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         slot_q <= '0;
      end else if (load_i) begin
         slot_q <= d_i;
      end else begin
         slot_q <= slot_q;
      end
   end

   assign q_o = slot_q;

endmodule

// File: rtl/exe_mem_pipe_reg.sv
// Elastic EXE->MEM pipeline register with a two-entry skid buffer.
// MAIN drives the outputs, SKID catches the one extra instruction that
// arrives in the cycle MEM stalls. in_ready is decoded from state flops
// only, so there is no combinational path from out_ready to in_ready.
// Ports:
//   clk, rst_n, flush                   - clock, async reset, squash
//   in_valid / in_ready                 - EXE-side handshake
//   pc_in, alu_result_in, st_value_in,
//   dest_in, mem_r_en_in, mem_w_en_in,
//   wb_en_in                            - EXE payload
//   out_valid / out_ready               - MEM-side handshake
//   pc, alu_result, st_value, dest      - head-entry payload
//   mem_r_en, mem_w_en, wb_en           - head-entry control, masked
//   occupancy                           - entries held (0..2)
module exe_mem_pipe_reg #(
   parameter int PC_W   = exe_mem_pkg::PC_W,
   parameter int DATA_W = exe_mem_pkg::DATA_W,
   parameter int DEST_W = exe_mem_pkg::DEST_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PC_W-1:0]   pc_in,
   input  logic [DATA_W-1:0] alu_result_in,
   input  logic [DATA_W-1:0] st_value_in,
   input  logic [DEST_W-1:0] dest_in,
   input  logic              mem_r_en_in,
   input  logic              mem_w_en_in,
   input  logic              wb_en_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PC_W-1:0]   pc,
   output logic [DATA_W-1:0] alu_result,
   output logic [DATA_W-1:0] st_value,
   output logic [DEST_W-1:0] dest,
   output logic              mem_r_en,
   output logic              mem_w_en,
   output logic              wb_en,
   output logic [1:0]        occupancy
);

   import exe_mem_pkg::*;

   localparam int PAY_W = PC_W + 2 * DATA_W + DEST_W + 3;

   state_e             state_q, state_d;
   logic [PAY_W-1:0]   in_pay_s;
   logic [PAY_W-1:0]   main_d, main_q, skid_q;
   logic               load_main_s, load_skid_s, main_from_skid_s;
   logic               in_fire_s, out_fire_s;
   logic               main_r_s, main_w_s, main_wb_s;

   assign in_pay_s = {pc_in, alu_result_in, st_value_in, dest_in,
                      mem_r_en_in, mem_w_en_in, wb_en_in};

   assign in_ready   = (state_q != FULL);
   assign out_valid  = (state_q != EMPTY);
   assign occupancy  = state_q;
   assign in_fire_s  = in_valid & in_ready;
   assign out_fire_s = out_valid & out_ready;

   // Next-state and slot-load decode; flush overrides every transition.
   always_comb begin
      state_d          = state_q;
      load_main_s      = 1'b0;
      load_skid_s      = 1'b0;
      main_from_skid_s = 1'b0;
      if (flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               if (in_fire_s) begin
                  state_d     = ONE;
                  load_main_s = 1'b1;
               end else begin
                  state_d = EMPTY;
               end
            end
            ONE: begin
               if (in_fire_s && out_fire_s) begin
                  state_d     = ONE;
                  load_main_s = 1'b1;
               end else if (in_fire_s) begin
                  state_d     = FULL;
                  load_skid_s = 1'b1;
               end else if (out_fire_s) begin
                  state_d = EMPTY;
               end else begin
                  state_d = ONE;
               end
            end
            FULL: begin
               // in_ready is low here, so only the drain side can move.
               if (out_fire_s) begin
                  state_d          = ONE;
                  load_main_s      = 1'b1;
                  main_from_skid_s = 1'b1;
               end else begin
                  state_d = FULL;
               end
            end
            default: begin
               state_d = EMPTY;
            end
         endcase
      end
   end

   // MAIN refills from SKID when draining a full buffer, else from EXE.
   always_comb begin
      if (main_from_skid_s) begin
         main_d = skid_q;
      end else begin
         main_d = in_pay_s;
      end
   end

   // Occupancy state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   payload_slot #(.W(PAY_W)) u_main (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .load_i (load_main_s),
      .d_i    (main_d),
      .q_o    (main_q)
   );

   payload_slot #(.W(PAY_W)) u_skid (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .load_i (load_skid_s),
      .d_i    (in_pay_s),
      .q_o    (skid_q)
   );

   assign {pc, alu_result, st_value, dest, main_r_s, main_w_s, main_wb_s} = main_q;

   // Stale payload is harmless; stale control bits are not, so mask them.
   assign mem_r_en = main_r_s  & out_valid;
   assign mem_w_en = main_w_s  & out_valid;
   assign wb_en    = main_wb_s & out_valid;

endmodule

// File: tb/tb_exe_mem_pipe_reg.sv
// Bench for exe_mem_pipe_reg: a queue model of the two-entry register is
// compared against the DUT every cycle, and directed sequences pin the
// model with hand-computed literal expectations.
module tb_exe_mem_pipe_reg;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] pc_in, alu_result_in, st_value_in;
   logic [4:0]  dest_in;
   logic        mem_r_en_in, mem_w_en_in, wb_en_in;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] pc, alu_result, st_value;
   logic [4:0]  dest;
   logic        mem_r_en, mem_w_en, wb_en;
   logic [1:0]  occupancy;

   int n_checks = 0;
   int n_pass   = 0;
   int n_deliv  = 0;

   exe_mem_pkg::exe_mem_payload_t mq[$];
   exe_mem_pkg::exe_mem_payload_t cur_in;
   logic m_in_fire, m_out_fire;

   exe_mem_pipe_reg dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .pc_in(pc_in), .alu_result_in(alu_result_in), .st_value_in(st_value_in),
      .dest_in(dest_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
      .wb_en_in(wb_en_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .pc(pc), .alu_result(alu_result), .st_value(st_value), .dest(dest),
      .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .wb_en(wb_en),
      .occupancy(occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Model: a FIFO of at most two entries, updated at each rising edge.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
      end else begin
         cur_in     = '{pc_in, alu_result_in, st_value_in, dest_in,
                        mem_r_en_in, mem_w_en_in, wb_en_in};
         m_in_fire  = in_valid && (mq.size() < 2);
         m_out_fire = out_ready && (mq.size() > 0);
         if (m_out_fire) n_deliv++;
         if (flush) begin
            mq.delete();
         end else begin
            if (m_out_fire) void'(mq.pop_front());
            if (m_in_fire) mq.push_back(cur_in);
         end
      end
   end

   // Per-cycle comparison of the DUT against the model.
   always @(negedge clk) begin
      chk("occupancy", 128'(occupancy), 128'(mq.size()));
      chk("in_ready", 128'(in_ready), 128'(mq.size() < 2));
      chk("out_valid", 128'(out_valid), 128'(mq.size() > 0));
      if (mq.size() > 0) begin
         chk("head", 128'({pc, alu_result, st_value, dest, mem_r_en, mem_w_en, wb_en}),
             128'(mq[0]));
      end else begin
         chk("ctrl_masked", 128'({mem_r_en, mem_w_en, wb_en}), 128'(3'b000));
      end
   end

   task automatic cyc(input logic v, input logic [31:0] p, input logic ordy,
                      input logic r, input logic w, input logic wb,
                      input logic [4:0] d, input logic fl);
      in_valid      = v;
      pc_in         = p;
      alu_result_in = p ^ 32'hA5A5_0000;
      st_value_in   = p + 32'd1;
      dest_in       = d;
      mem_r_en_in   = r;
      mem_w_en_in   = w;
      wb_en_in      = wb;
      out_ready     = ordy;
      flush         = fl;
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      pc_in = 32'd0; alu_result_in = 32'd0; st_value_in = 32'd0; dest_in = 5'd0;
      mem_r_en_in = 1'b0; mem_w_en_in = 1'b0; wb_en_in = 1'b0;

      // Reset state
      @(negedge clk); #1;
      chk("rst_out_valid", 128'(out_valid), 128'(1'b0));
      chk("rst_in_ready", 128'(in_ready), 128'(1'b1));
      chk("rst_occ", 128'(occupancy), 128'(2'd0));
      chk("rst_pc", 128'(pc), 128'(32'd0));
      chk("rst_ctrl", 128'({mem_r_en, mem_w_en, wb_en}), 128'(3'b000));
      rst_n = 1'b1;

      // Stream with out_ready high
      cyc(1'b1, 32'h04, 1'b1, 1'b1, 1'b0, 1'b1, 5'd1, 1'b0);
      chk("s_pc04", 128'(pc), 128'(32'h04));
      chk("s_alu04", 128'(alu_result), 128'(32'hA5A5_0004));
      chk("s_occ1", 128'(occupancy), 128'(2'd1));
      cyc(1'b1, 32'h08, 1'b1, 1'b0, 1'b1, 1'b0, 5'd2, 1'b0);
      chk("s_pc08", 128'(pc), 128'(32'h08));
      chk("s_wen08", 128'(mem_w_en), 128'(1'b1));
      cyc(1'b1, 32'h0C, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0);
      chk("s_pc0C", 128'(pc), 128'(32'h0C));
      chk("s_rdy", 128'(in_ready), 128'(1'b1));
      cyc(1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
      chk("s_empty", 128'(out_valid), 128'(1'b0));

      // Stall absorb
      cyc(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 1'b1, 5'd4, 1'b0);
      chk("st_pc10", 128'(pc), 128'(32'h10));
      cyc(1'b1, 32'h14, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0);
      chk("st_occ2", 128'(occupancy), 128'(2'd2));
      chk("st_rdy0", 128'(in_ready), 128'(1'b0));
      cyc(1'b1, 32'h18, 1'b0, 1'b0, 1'b0, 1'b1, 5'd6, 1'b0);
      chk("st_hold10", 128'(pc), 128'(32'h10));
      cyc(1'b1, 32'h18, 1'b1, 1'b0, 1'b0, 1'b1, 5'd6, 1'b0);
      chk("st_pc14", 128'(pc), 128'(32'h14));
      chk("st_occ1", 128'(occupancy), 128'(2'd1));
      cyc(1'b1, 32'h18, 1'b1, 1'b0, 1'b0, 1'b1, 5'd6, 1'b0);
      chk("st_pc18", 128'(pc), 128'(32'h18));
      cyc(1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
      chk("st_drained", 128'(occupancy), 128'(2'd0));

      // Flush while FULL with a simultaneous offer
      cyc(1'b1, 32'h1C, 1'b0, 1'b0, 1'b0, 1'b0, 5'd7, 1'b0);
      cyc(1'b1, 32'h28, 1'b0, 1'b0, 1'b0, 1'b0, 5'd8, 1'b0);
      chk("f_full", 128'(occupancy), 128'(2'd2));
      cyc(1'b1, 32'h20, 1'b0, 1'b0, 1'b1, 1'b0, 5'd9, 1'b1);
      chk("f_valid0", 128'(out_valid), 128'(1'b0));
      chk("f_wen0", 128'(mem_w_en), 128'(1'b0));
      chk("f_occ0", 128'(occupancy), 128'(2'd0));
      chk("f_rdy1", 128'(in_ready), 128'(1'b1));
      cyc(1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
      chk("f_still_empty", 128'(out_valid), 128'(1'b0));

      // Flush in ONE discards a simultaneous accepted input
      cyc(1'b1, 32'h50, 1'b0, 1'b0, 1'b0, 1'b0, 5'd10, 1'b0);
      cyc(1'b1, 32'h54, 1'b0, 1'b0, 1'b0, 1'b0, 5'd11, 1'b1);
      chk("f1_occ0", 128'(occupancy), 128'(2'd0));

      // Control masking on drain
      cyc(1'b1, 32'h24, 1'b0, 1'b0, 1'b0, 1'b1, 5'd31, 1'b0);
      chk("m_wb1", 128'(wb_en), 128'(1'b1));
      chk("m_dest31", 128'(dest), 128'(5'd31));
      cyc(1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
      chk("m_wb0", 128'(wb_en), 128'(1'b0));
      chk("m_dest_stale", 128'(dest), 128'(5'd31));

      // Asynchronous reset while FULL
      cyc(1'b1, 32'h30, 1'b0, 1'b1, 1'b0, 1'b1, 5'd12, 1'b0);
      cyc(1'b1, 32'h34, 1'b0, 1'b1, 1'b0, 1'b1, 5'd13, 1'b0);
      chk("a_full", 128'(occupancy), 128'(2'd2));
      #2 rst_n = 1'b0;
      #1;
      chk("a_valid0", 128'(out_valid), 128'(1'b0));
      chk("a_rdy1", 128'(in_ready), 128'(1'b1));
      chk("a_occ0", 128'(occupancy), 128'(2'd0));
      chk("a_pc0", 128'(pc), 128'(32'd0));
      chk("a_ctrl0", 128'({mem_r_en, wb_en}), 128'(2'b00));
      @(negedge clk); #1;
      rst_n = 1'b1;
      cyc(1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 1'b1, 5'd14, 1'b0);
      chk("a_pc40", 128'(pc), 128'(32'h40));
      chk("a_occ1", 128'(occupancy), 128'(2'd1));
      cyc(1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);

      // Random valid/ready traffic against the model
      for (int i = 0; i < 10000; i++) begin
         cyc(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
             1'($urandom_range(0, 63) == 0));
      end
      chk("deliveries", 128'(n_deliv > 1000), 128'(1'b1));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
